// File: rtl/gbd_frame_ring_ctrl_if.sv
// Request/response bundle for gbd_frame_ring_ctrl: producer, consumer, register-shadow
// ports and ring status. The DUT takes the slave modport.
interface gbd_frame_ring_ctrl_if #(
  parameter int unsigned NUM_BUFS  = 2,
  parameter int unsigned BUF_BYTES = 256,
  parameter int unsigned REG_BYTES = 64,
  parameter int unsigned DATA_W    = 8
) ();
  localparam int unsigned OffW  = $clog2(BUF_BYTES);
  localparam int unsigned RegAW = $clog2(REG_BYTES);
  localparam int unsigned CntW  = $clog2(NUM_BUFS + 1);

  // Producer
  logic              wr_buf_req;
  logic [OffW-1:0]   wr_buf_off;
  logic [DATA_W-1:0] wr_buf_data;
  logic              wr_commit;
  // Consumer
  logic              rd_buf_req;
  logic [OffW-1:0]   rd_buf_off;
  logic [DATA_W-1:0] rd_buf_data;
  logic              rd_buf_ready;
  logic              rd_release;
  // Register shadow
  logic              reg_wr_req;
  logic [RegAW-1:0]  reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_rd_req;
  logic [RegAW-1:0]  reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_ready;
  // Ring status
  logic [CntW-1:0]   buf_count;
  logic              buf_avail;
  logic              overrun;
  logic              underrun;

  modport master (
    output wr_buf_req, wr_buf_off, wr_buf_data, wr_commit,
    output rd_buf_req, rd_buf_off, rd_release,
    output reg_wr_req, reg_wr_addr, reg_wr_data, reg_rd_req, reg_rd_addr,
    input  rd_buf_data, rd_buf_ready, reg_rd_data, reg_rd_ready,
    input  buf_count, buf_avail, overrun, underrun
  );

  modport slave (
    input  wr_buf_req, wr_buf_off, wr_buf_data, wr_commit,
    input  rd_buf_req, rd_buf_off, rd_release,
    input  reg_wr_req, reg_wr_addr, reg_wr_data, reg_rd_req, reg_rd_addr,
    output rd_buf_data, rd_buf_ready, reg_rd_data, reg_rd_ready,
    output buf_count, buf_avail, overrun, underrun
  );
endinterface

// File: rtl/gbd_frame_ring_ctrl.sv
// gbd_frame_ring_ctrl: single-port BRAM holding NUM_BUFS tile buffers managed as a ring plus
// a register-shadow region, shared by four requesters with fixed-priority arbitration.
// Optional macro GBD_RING_DROP_OLDEST_EN: a commit while full drops the oldest buffer
// instead of the newest.
module gbd_frame_ring_ctrl #(
  parameter int unsigned NUM_BUFS  = 2,
  parameter int unsigned BUF_BYTES = 256,
  parameter int unsigned REG_BYTES = 64,
  parameter int unsigned DATA_W    = 8
) (
  input logic                  sys_clock,
  input logic                  resetn,
  gbd_frame_ring_ctrl_if.slave bus_io
);
  localparam int unsigned MemDepth = NUM_BUFS * BUF_BYTES + REG_BYTES;
  localparam int unsigned AddrW    = $clog2(MemDepth);
  localparam int unsigned OffW     = $clog2(BUF_BYTES);
  localparam int unsigned RegAW    = $clog2(REG_BYTES);
  localparam int unsigned PtrW     = $clog2(NUM_BUFS);
  localparam int unsigned CntW     = $clog2(NUM_BUFS + 1);

  localparam logic [AddrW-1:0] BufBytesA = AddrW'(BUF_BYTES);
  localparam logic [AddrW-1:0] RegBase   = AddrW'(NUM_BUFS * BUF_BYTES);
  localparam logic [PtrW-1:0]  LastPtr   = PtrW'(NUM_BUFS - 1);
  localparam logic [CntW-1:0]  FullCnt   = CntW'(NUM_BUFS);

  // State names the access granted in the previous cycle; read states emit the ready pulse.
  typedef enum logic [1:0] {StIdle, StWrite, StRespReg, StRespBuf} state_e;
  state_e state_q, state_d;

  logic              regwr_pend_q, wrbuf_pend_q, regrd_pend_q, rdbuf_pend_q;
  logic [RegAW-1:0]  regwr_addr_q, regrd_addr_q;
  logic [OffW-1:0]   wrbuf_off_q, rdbuf_off_q;
  logic [DATA_W-1:0] regwr_data_q, wrbuf_data_q;
  logic              gnt_regwr, gnt_wrbuf, gnt_regrd, gnt_rdbuf;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overrun_q, overrun_d, underrun_q, underrun_d;

  logic [DATA_W-1:0] mem_q [MemDepth];
  logic [DATA_W-1:0] mem_rdata_q, mem_wdata;
  logic [AddrW-1:0]  mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] rdbuf_hold_q, regrd_hold_q;
  logic              rd_ready, reg_ready;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Capture request pulses; a repeat pulse overwrites the latched fields, a grant clears.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      regwr_pend_q <= 1'b0;
      wrbuf_pend_q <= 1'b0;
      regrd_pend_q <= 1'b0;
      rdbuf_pend_q <= 1'b0;
      regwr_addr_q <= '0;
      regrd_addr_q <= '0;
      wrbuf_off_q  <= '0;
      rdbuf_off_q  <= '0;
      regwr_data_q <= '0;
      wrbuf_data_q <= '0;
    end else begin
      if (bus_io.reg_wr_req) begin
        regwr_pend_q <= 1'b1;
        regwr_addr_q <= bus_io.reg_wr_addr;
        regwr_data_q <= bus_io.reg_wr_data;
      end else if (gnt_regwr) begin
        regwr_pend_q <= 1'b0;
      end
      if (bus_io.wr_buf_req) begin
        wrbuf_pend_q <= 1'b1;
        wrbuf_off_q  <= bus_io.wr_buf_off;
        wrbuf_data_q <= bus_io.wr_buf_data;
      end else if (gnt_wrbuf) begin
        wrbuf_pend_q <= 1'b0;
      end
      if (bus_io.reg_rd_req) begin
        regrd_pend_q <= 1'b1;
        regrd_addr_q <= bus_io.reg_rd_addr;
      end else if (gnt_regrd) begin
        regrd_pend_q <= 1'b0;
      end
      if (bus_io.rd_buf_req) begin
        rdbuf_pend_q <= 1'b1;
        rdbuf_off_q  <= bus_io.rd_buf_off;
      end else if (gnt_rdbuf) begin
        rdbuf_pend_q <= 1'b0;
      end
    end
  end

  // Fixed priority grant: reg_wr > wr_buf > reg_rd > rd_buf.
  always_comb begin
    gnt_regwr = regwr_pend_q;
    gnt_wrbuf = wrbuf_pend_q && !regwr_pend_q;
    gnt_regrd = regrd_pend_q && !regwr_pend_q && !wrbuf_pend_q;
    gnt_rdbuf = rdbuf_pend_q && !regwr_pend_q && !wrbuf_pend_q && !regrd_pend_q;
  end

  // BRAM port mux; buffer pointers are sampled in the grant cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_regwr) begin
      mem_we    = 1'b1;
      mem_addr  = RegBase + AddrW'(regwr_addr_q);
      mem_wdata = regwr_data_q;
    end else if (gnt_wrbuf) begin
      mem_we    = 1'b1;
      mem_addr  = AddrW'(wr_ptr_q) * BufBytesA + AddrW'(wrbuf_off_q);
      mem_wdata = wrbuf_data_q;
    end else if (gnt_regrd) begin
      mem_addr  = RegBase + AddrW'(regrd_addr_q);
    end else if (gnt_rdbuf) begin
      mem_addr  = AddrW'(rd_ptr_q) * BufBytesA + AddrW'(rdbuf_off_q);
    end
  end

  // Inferred single-port BRAM with registered read data.
  always_ff @(posedge sys_clock) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
    mem_rdata_q <= mem_q[mem_addr];
  end

  // Arbiter state register.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbiter next state: record which kind of access this cycle's grant issued.
  always_comb begin
    state_d = StIdle;
    if (gnt_regwr || gnt_wrbuf) begin
      state_d = StWrite;
    end else if (gnt_regrd) begin
      state_d = StRespReg;
    end else if (gnt_rdbuf) begin
      state_d = StRespBuf;
    end
  end

  // Arbiter outputs: ready pulses in the cycle after a read grant.
  always_comb begin
    rd_ready  = 1'b0;
    reg_ready = 1'b0;
    unique case (state_q)
      StRespReg: reg_ready = 1'b1;
      StRespBuf: rd_ready  = 1'b1;
      default:   ;
    endcase
  end

  // Hold the last returned data per read source until its next ready pulse.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      rdbuf_hold_q <= '0;
      regrd_hold_q <= '0;
    end else begin
      if (rd_ready)  rdbuf_hold_q <= mem_rdata_q;
      if (reg_ready) regrd_hold_q <= mem_rdata_q;
    end
  end

  // Ring bookkeeping for commit/release pulses, including the full/empty corner cases.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (bus_io.wr_commit && bus_io.rd_release) begin
      if (count_q == '0) begin
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        count_d    = count_q + CntW'(1);
        underrun_d = 1'b1;
      end else begin
        // When full the release frees a slot first, so the commit always fits.
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
    end else if (bus_io.wr_commit) begin
      if (count_q != FullCnt) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CntW'(1);
      end else begin
        overrun_d = 1'b1;
`ifdef GBD_RING_DROP_OLDEST_EN
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
`endif
      end
    end else if (bus_io.rd_release) begin
      if (count_q != '0) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - CntW'(1);
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  // Ring state registers; sticky flags clear only on reset.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus_io.rd_buf_ready = rd_ready;
  assign bus_io.rd_buf_data  = rd_ready ? mem_rdata_q : rdbuf_hold_q;
  assign bus_io.reg_rd_ready = reg_ready;
  assign bus_io.reg_rd_data  = reg_ready ? mem_rdata_q : regrd_hold_q;
  assign bus_io.buf_count    = count_q;
  assign bus_io.buf_avail    = (count_q != '0);
  assign bus_io.overrun      = overrun_q;
  assign bus_io.underrun     = underrun_q;

endmodule
